// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter controller and the counter it drives:
// state codes, register map, CTRL/STATUS bit positions.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_DONE  = 2'd3
    } fsm_state_e;

    localparam logic [7:0] CS_RESET = 8'd0;
    localparam logic [7:0] CS_RUN   = 8'd1;
    localparam logic [7:0] CS_HALT  = 8'd2;

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_INTERVAL = 3'd1;
    localparam logic [2:0] A_COMPARE  = 3'd2;
    localparam logic [2:0] A_STATUS   = 3'd3;
    localparam logic [2:0] A_COUNT    = 3'd4;

    localparam int CTRL_START   = 0;
    localparam int CTRL_HALT    = 1;
    localparam int CTRL_CLEAR   = 2;
    localparam int CTRL_ONESHOT = 3;

    localparam int ST_DONE = 2;
    localparam int ST_PEND = 3;

    // S_DONE presents to the counter as halted.
    function automatic logic [7:0] state_code(input fsm_state_e s);
        case (s)
            S_RESET: return CS_RESET;
            S_RUN:   return CS_RUN;
            default: return CS_HALT;
        endcase
    endfunction

endpackage

// File: rtl/counter_ctrl_regs.sv
// Register file and registered read mux for counter_ctrl.
// Pending-interrupt flag only exists when COUNTER_CTRL_IRQ_EN is defined.
module counter_ctrl_regs
    import counter_ctrl_pkg::*;
#(
    parameter logic [31:0] DEFAULT_INTERVAL = 32'd0,
    parameter logic [31:0] DEFAULT_COMPARE  = 32'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] cnt_value,
    input  fsm_state_e  state,
    input  logic        match,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic [31:0] interval,
    output logic [31:0] compare,
    output logic        oneshot
`ifdef COUNTER_CTRL_IRQ_EN
    ,
    output logic        pending
`endif
);

    logic        done;
    logic [15:0] wrap;
    logic        pend_bit;
    logic        cfg_ok;
    logic [31:0] rd_mux;

    // Configuration is frozen while the counter is running.
    assign cfg_ok = (state != S_RUN);

`ifdef COUNTER_CTRL_IRQ_EN
    assign pend_bit = pending;
`else
    assign pend_bit = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_CTRL:     rd_mux[CTRL_ONESHOT] = oneshot;
            A_INTERVAL: rd_mux = interval;
            A_COMPARE:  rd_mux = compare;
            A_STATUS: begin
                rd_mux[1:0]     = state;
                rd_mux[ST_DONE] = done;
                rd_mux[ST_PEND] = pend_bit;
                rd_mux[31:16]   = wrap;
            end
            A_COUNT:    rd_mux = cnt_value;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            interval <= DEFAULT_INTERVAL;
            compare  <= DEFAULT_COMPARE;
            oneshot  <= 1'b0;
            done     <= 1'b0;
            wrap     <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
`ifdef COUNTER_CTRL_IRQ_EN
            pending  <= 1'b0;
`endif
        end else begin
            rvalid <= rd_en;
            if (rd_en)
                rdata <= rd_mux;
            if (wr_en) begin
                case (addr)
                    A_CTRL:     oneshot <= wdata[CTRL_ONESHOT];
                    A_INTERVAL: if (cfg_ok) interval <= wdata;
                    A_COMPARE:  if (cfg_ok) compare <= wdata;
                    A_STATUS: begin
                        if (wdata[ST_DONE]) done <= 1'b0;
`ifdef COUNTER_CTRL_IRQ_EN
                        if (wdata[ST_PEND]) pending <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
            // A match in the same cycle as a write-1-to-clear keeps the flag set.
            if (match && oneshot)
                done <= 1'b1;
            if (match && !oneshot && wrap != 16'hFFFF)
                wrap <= wrap + 16'd1;
`ifdef COUNTER_CTRL_IRQ_EN
            if (match)
                pending <= 1'b1;
`endif
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Counter controller: command FSM driving an external counter, plus registers.
// Define COUNTER_CTRL_IRQ_EN to add the level irq output.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter logic [31:0] DEFAULT_INTERVAL = 32'd0,
    parameter logic [31:0] DEFAULT_COMPARE  = 32'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic [7:0]  cnt_state,
    output logic [31:0] cnt_interval,
    input  logic [31:0] cnt_value
`ifdef COUNTER_CTRL_IRQ_EN
    ,
    output logic        irq
`endif
);

    fsm_state_e  state;
    logic        wrap_pulse;
    logic        restart;
    logic [31:0] compare;
    logic        oneshot;
    logic        ctrl_wr, cmd_clear, cmd_halt, cmd_start, match;

    assign ctrl_wr   = wr_en && (addr == A_CTRL);
    assign cmd_clear = ctrl_wr && wdata[CTRL_CLEAR];
    assign cmd_halt  = ctrl_wr && wdata[CTRL_HALT];
    assign cmd_start = ctrl_wr && wdata[CTRL_START];

    // No match while the counter is being reset by a periodic wrap pulse.
    assign match = (compare != '0) && (state == S_RUN) && !wrap_pulse &&
                   (cnt_value == compare) && !cmd_clear && !cmd_halt;

    counter_ctrl_regs #(
        .DEFAULT_INTERVAL (DEFAULT_INTERVAL),
        .DEFAULT_COMPARE  (DEFAULT_COMPARE)
    ) u_regs (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wdata     (wdata),
        .cnt_value (cnt_value),
        .state     (state),
        .match     (match),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .interval  (cnt_interval),
        .compare   (compare),
        .oneshot   (oneshot)
`ifdef COUNTER_CTRL_IRQ_EN
        ,
        .pending   (irq)
`endif
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_RESET;
            cnt_state  <= CS_RESET;
            wrap_pulse <= 1'b0;
            restart    <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            restart    <= 1'b0;
            if (cmd_clear) begin
                state     <= S_RESET;
                cnt_state <= CS_RESET;
            end else if (cmd_halt) begin
                if (state == S_RUN) begin
                    state     <= S_HALT;
                    cnt_state <= CS_HALT;
                end
            end else if (match) begin
                if (oneshot) begin
                    state     <= S_DONE;
                    cnt_state <= state_code(S_DONE);
                end else begin
                    wrap_pulse <= 1'b1;
                    cnt_state  <= CS_RESET;
                end
            end else if (cmd_start || restart) begin
                // Restart from S_DONE passes through one reset cycle first.
                case (state)
                    S_RESET, S_HALT: begin
                        state     <= S_RUN;
                        cnt_state <= CS_RUN;
                    end
                    S_DONE: begin
                        state     <= S_RESET;
                        cnt_state <= CS_RESET;
                        restart   <= 1'b1;
                    end
                    default: cnt_state <= state_code(state);
                endcase
            end else begin
                cnt_state <= state_code(state);
            end
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_counter_ctrl;

    localparam logic [31:0] DEF_INT = 32'd10;
    localparam logic [31:0] DEF_CMP = 32'd0;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] cnt_value = 32'd0;
    logic [31:0] rdata;
    logic        rvalid;
    logic [7:0]  cnt_state;
    logic [31:0] cnt_interval;
`ifdef COUNTER_CTRL_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    counter_ctrl #(
        .DEFAULT_INTERVAL (DEF_INT),
        .DEFAULT_COMPARE  (DEF_CMP)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .cnt_state    (cnt_state),
        .cnt_interval (cnt_interval),
        .cnt_value    (cnt_value)
`ifdef COUNTER_CTRL_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: m_st is the spec state number (0 reset, 1 run, 2 halt, 3 done).
    int          m_st;
    bit          m_pulse, m_restart, m_one, m_done, m_pend, m_rvalid;
    logic [31:0] m_intv, m_cmp, m_rdata;
    int          m_wrap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [2:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            3'd0: v[3] = m_one;
            3'd1: v = m_intv;
            3'd2: v = m_cmp;
            3'd3: begin
                v[1:0] = 2'(m_st);
                v[2] = m_done;
`ifdef COUNTER_CTRL_IRQ_EN
                v[3] = m_pend;
`endif
                v[31:16] = 16'(m_wrap);
            end
            3'd4: v = cnt_value;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] exp_cs();
        if (m_pulse || m_st == 0) return 8'd0;
        if (m_st == 1) return 8'd1;
        return 8'd2;
    endfunction

    task automatic model_reset();
        m_st = 0; m_pulse = 0; m_restart = 0; m_one = 0; m_done = 0; m_pend = 0;
        m_rvalid = 0; m_rdata = 32'd0; m_intv = DEF_INT; m_cmp = DEF_CMP; m_wrap = 0;
    endtask

    task automatic model_step();
        bit ctrl, clr, hlt, go, match, one0;
        int st0;
        st0   = m_st;
        one0  = m_one;
        ctrl  = wr_en && addr == 3'd0;
        clr   = ctrl && wdata[2];
        hlt   = ctrl && wdata[1];
        go    = (ctrl && wdata[0]) || m_restart;
        match = m_cmp != 0 && st0 == 1 && !m_pulse && cnt_value == m_cmp && !clr && !hlt;
        m_rvalid = rd_en;
        if (rd_en) m_rdata = rd_model(addr);
        if (wr_en) begin
            if (addr == 3'd0) m_one = wdata[3];
            if (addr == 3'd1 && st0 != 1) m_intv = wdata;
            if (addr == 3'd2 && st0 != 1) m_cmp = wdata;
            if (addr == 3'd3 && wdata[2]) m_done = 0;
            if (addr == 3'd3 && wdata[3]) m_pend = 0;
        end
        if (match) begin
            m_pend = 1;
            if (one0) m_done = 1;
            else if (m_wrap < 65535) m_wrap++;
        end
        m_pulse = 0;
        m_restart = 0;
        if (clr) m_st = 0;
        else if (hlt) begin
            if (st0 == 1) m_st = 2;
        end else if (match) begin
            if (one0) m_st = 3;
            else m_pulse = 1;
        end else if (go) begin
            if (st0 == 0 || st0 == 2) m_st = 1;
            else if (st0 == 3) begin m_st = 0; m_restart = 1; end
        end
    endtask

    always @(posedge clk) if (resetn) model_step();

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        if (resetn) begin
            check("cnt_state", 32'(cnt_state), 32'(exp_cs()));
            check("cnt_interval", cnt_interval, m_intv);
            check("rvalid", 32'(rvalid), 32'(m_rvalid));
            if (m_rvalid) check("rdata", rdata, m_rdata);
`ifdef COUNTER_CTRL_IRQ_EN
            check("irq", 32'(irq), 32'(m_pend));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; rd_en = 1'b0; addr = a; wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        rd_en = 1'b1; wr_en = 1'b0; addr = a;
        tick();
        d = rdata;
        rd_en = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        #2 resetn = 1'b0;
        #1;
        check({tag, "_cnt_state"}, 32'(cnt_state), 32'd0);
        check({tag, "_cnt_interval"}, cnt_interval, DEF_INT);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
`ifdef COUNTER_CTRL_IRQ_EN
        check({tag, "_irq"}, 32'(irq), 32'd0);
`endif
        model_reset();
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] v, d;
        model_reset();
        #12;
        check("rst_cnt_state", 32'(cnt_state), 32'd0);
        check("rst_cnt_interval", cnt_interval, DEF_INT);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        wr(3'd1, 32'd3);
        wr(3'd0, 32'h1);
        check("start_cnt_state", 32'(cnt_state), 32'd1);
        check("start_interval", cnt_interval, 32'd3);

        wr(3'd0, 32'h4);
        wr(3'd2, 32'd5);
        wr(3'd0, 32'h9);
        cnt_value = 32'd5;
        tick();
        cnt_value = 32'd0;
        check("oneshot_cnt_state", 32'(cnt_state), 32'd2);
        rd(3'd3, v);
        check("oneshot_done", 32'(v[2]), 32'd1);
        check("oneshot_state_code", 32'(v[1:0]), 32'd3);

        wr(3'd0, 32'h4);
        wr(3'd3, 32'hC);
        wr(3'd2, 32'd4);
        wr(3'd0, 32'h1);
        for (int k = 0; k < 2; k++) begin
            cnt_value = 32'd4;
            tick();
            check("periodic_pulse", 32'(cnt_state), 32'd0);
            cnt_value = 32'd0;
            tick();
            check("periodic_run", 32'(cnt_state), 32'd1);
        end
        rd(3'd3, v);
        check("periodic_wrap", 32'(v[31:16]), 32'd2);

        wr(3'd1, 32'd9);
        check("intv_run_locked", cnt_interval, 32'd3);
        wr(3'd0, 32'h2);
        check("halt_cnt_state", 32'(cnt_state), 32'd2);
        wr(3'd1, 32'd9);
        check("intv_halt_write", cnt_interval, 32'd9);

        wr(3'd0, 32'h1);
        check("restart_run", 32'(cnt_state), 32'd1);
        wr(3'd0, 32'h7);
        check("clear_wins", 32'(cnt_state), 32'd0);

        wr_en = 1'b1; rd_en = 1'b1; addr = 3'd1; wdata = 32'd7;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdwr_pre_value", rdata, 32'd9);
        check("rdwr_written", cnt_interval, 32'd7);
        rd(3'd5, v);
        check("addr5_zero", v, 32'd0);
        cnt_value = 32'hABCD1234;
        rd(3'd4, v);
        check("count_read", v, 32'hABCD1234);
        cnt_value = 32'd0;

`ifdef COUNTER_CTRL_IRQ_EN
        wr(3'd3, 32'hC);
        wr(3'd0, 32'h1);
        cnt_value = 32'd4;
        tick();
        cnt_value = 32'd0;
        check("irq_set", 32'(irq), 32'd1);
        wr(3'd3, 32'h8);
        check("irq_clear", 32'(irq), 32'd0);
`endif

        wr(3'd0, 32'h1);
        async_reset("midrun");

        for (int i = 0; i < 3000; i++) begin
            wr_en = ($urandom_range(0, 2) == 0);
            rd_en = ($urandom_range(0, 2) == 0);
            addr  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            if (addr == 3'd0) begin
                d = 32'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) d[2] = 1'b0;
            end else if (addr == 3'd3) begin
                d = 32'($urandom_range(0, 15));
            end else if ($urandom_range(0, 9) == 0) begin
                d = $urandom;
            end else begin
                d = 32'($urandom_range(0, 6));
            end
            wdata = d;
            cnt_value = 32'($urandom_range(0, 6));
            tick();
            if ($urandom_range(0, 499) == 0) async_reset("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_INTERVAL, 32'd0, INTERVAL register value after reset.
REQ-002 SHALL have parameter DEFAULT_COMPARE, 32'd0, COMPARE register value after reset; 0 disables matching.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 wr_en  in  1  register write strobe, one-cycle.
REQ-006 rd_en  in  1  register read strobe, one-cycle.
REQ-007 addr  in  3  word address: 0 CTRL, 1 INTERVAL, 2 COMPARE, 3 STATUS, 4 COUNT.
REQ-008 wdata  in  32  write data.
REQ-009 rdata  out  32  read data, registered.
REQ-010 rvalid  out  1  high exactly one cycle after an accepted rd_en.
REQ-011 cnt_state  out  8  to counter: 8'd0 reset, 8'd1 run, 8'd2 halt.
REQ-012 cnt_interval  out  32  to counter: tick interval.
REQ-013 cnt_value  in  32  counter's current count.
REQ-014 irq  out  1  level interrupt (only with COUNTER_CTRL_IRQ_EN).

Function
REQ-015 FSM states: S_RESET, S_RUN, S_HALT, S_DONE; cnt_state = 0,1,2,2 respectively; registered, changes the cycle after the causing event.
REQ-016 CTRL write bits: [0] start, [1] halt, [2] clear, [3] oneshot (bit 3 stored as mode, bits 0-2 self-clearing commands).
REQ-017 Command priority same write: clear > halt > start.
REQ-018 Transitions: S_RESET/S_HALT -start-> S_RUN; S_RUN -halt-> S_HALT; any -clear-> S_RESET; S_DONE -start-> S_RESET (restart via clear cycle) then S_RUN.
REQ-019 Match: COMPARE != 0, state S_RUN and cnt_value == COMPARE.
REQ-020 Match in oneshot: -> S_DONE next cycle, done flag set.
REQ-021 Match in periodic: cnt_state = 8'd0 for exactly one cycle, then 8'd1; wrap count increments (saturating at 16'hFFFF).
REQ-022 Match and halt/clear in same cycle: command wins, no match effect.
REQ-023 INTERVAL/COMPARE writes accepted only in S_RESET/S_HALT/S_DONE; ignored in S_RUN.
REQ-024 STATUS read: [1:0] FSM state code, [2] done, [3] irq pending, [31:16] wrap count; write 1 to bit 2/3 clears done/pending.
REQ-025 COUNT read returns cnt_value sampled at rd_en; reads of addr 5-7 return 0.
REQ-026 wr_en and rd_en same cycle: both serviced; read returns pre-write value.

Reset
REQ-027 resetn low: FSM S_RESET, cnt_state 0, cnt_interval DEFAULT_INTERVAL, COMPARE DEFAULT_COMPARE, oneshot 0, done 0, pending 0, wrap 0, rdata 0, rvalid 0, irq 0.
REQ-028 Reset mid-RUN takes effect immediately (asynchronous); no pending command survives.

Configuration
REQ-029 Macro COUNTER_CTRL_IRQ_EN defined: irq port exists, pending set on every match, irq = pending.
REQ-030 Macro undefined: irq port absent, STATUS[3] reads 0, no pending logic.

Structure
REQ-031 Shared package holds state codes (8'd0/1/2), register address constants and CTRL bit positions, also used by counter.
REQ-032 One sub-module natural: counter_ctrl_regs (register file + read mux); FSM in top.

Verification
REQ-033 Reset, INTERVAL=3, start -> cnt_state 1 one cycle after write; cnt_interval 3.
REQ-034 Oneshot, COMPARE=5 -> on cnt_value 5 state S_DONE, cnt_state 2, STATUS[2]=1.
REQ-035 Periodic, COMPARE=4 -> one-cycle cnt_state 0 pulse per match, STATUS[31:16]=2 after two matches.
REQ-036 CTRL write 3'b111 in S_RUN -> S_RESET (clear wins), cnt_state 0.
REQ-037 INTERVAL write 9 during S_RUN -> cnt_interval unchanged; after halt, write 9 -> 9.
REQ-038 IRQ build: match -> irq 1; STATUS write 32'h8 -> irq 0 next cycle; resetn low mid-RUN -> all outputs reset values.
